keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
Matrix keypad scanner: the input-side counterpart of the multiplexed 7-segment display driver. The display strobes digit selects and drives segments; this block strobes row selects and reads columns back. It drives one row of a 4x4 keypad low at a time, samples the active-low columns, and debounces over whole scans. It emits one strobe per confirmed key press for the clock's time-set logic, and runs on the same 2 kHz PLL clock.

Parameters:
SCAN_DIVIDER, 8, clk_in cycles each row stays driven; must be >= 3.
DEBOUNCE_SCANS, 4, consecutive identical full scans required to confirm a press or a release; must be >= 1.

Ports:
clk_in  input  1  single clock (2 kHz PLL clock)
reset  input  1  asynchronous, active-low reset
col_in  input  4  keypad columns, active-low, externally pulled up, asynchronous to clk_in
row_out  output  4  row drive, active-low one-hot
key_valid  output  1  one-cycle strobe: new key confirmed
key_code  output  4  code of the confirmed key (row*4 + col); stable while key_held
key_held  output  1  high from confirmation until release is confirmed

Behaviour:
- One clock, clk_in. reset is asynchronous and active-low. All flops clear immediately on reset assertion.
- Reset values:
  - row_out=4'b1110, key_valid=0, key_code=0, key_held=0.
  - Column synchronizer=4'b1111, row index=0, slot counter=0, FSM=IDLE, debounce count=0, snapshot=0.
- col_in passes through a 2-flop synchronizer before any use.
- Row timing:
  - Slot counter runs 0..SCAN_DIVIDER-1. On wrap, row index advances 0→1→2→3→0.
  - row_out = ~(1<<row index), so the sequence is 1110, 1101, 1011, 0111.
  - Scan period = 4*SCAN_DIVIDER cycles (32 cycles = 16 ms at default).
- Sampling:
  - Sample when slot counter == SCAN_DIVIDER-1 (last cycle of the slot).
  - Store the inverted synchronized columns into snapshot bits [row*4 +: 4].
  - The sample taken in row 3's slot completes a scan. A scan_done strobe fires on the next clk_in edge, with the full 16-bit snapshot registered.
- Scan classification, at scan_done:
  - NONE: no bits set.
  - SINGLE(k): exactly one bit k set.
  - MULTI: two or more bits set (ghosting/rollover).
- Debounce FSM, evaluated only on scan_done; count saturates at DEBOUNCE_SCANS:
  - IDLE:
    - SINGLE(k) → DEBOUNCE_PRESS, cand=k, count=1; if DEBOUNCE_SCANS==1, confirm immediately.
    - NONE or MULTI → stay.
  - DEBOUNCE_PRESS:
    - SINGLE(cand) → count+1. When count reaches DEBOUNCE_SCANS → PRESSED, key_code=cand, key_held=1, key_valid=1 for exactly one cycle.
    - Any other result → IDLE, count=0. A different single key is picked up on the following scan; no carry-over.
  - PRESSED:
    - NONE → DEBOUNCE_RELEASE, count=1.
    - SINGLE (any key) or MULTI → stay, no new strobe. No n-key rollover.
  - DEBOUNCE_RELEASE:
    - NONE → count+1. When count reaches DEBOUNCE_SCANS → IDLE, key_held=0, count=0; key_code keeps its last value.
    - Any key present → PRESSED, count=0, no strobe (release bounce suppressed).
- Latency: key_valid asserts on the scan_done evaluation edge, one cycle after the final row-3 sample of the DEBOUNCE_SCANS-th confirming scan.
- Reset mid-scan or mid-debounce: everything returns to reset values. A key held through reset is re-detected as a new press and produces a strobe after DEBOUNCE_SCANS scans.
- key_valid is never asserted in two consecutive cycles.

Decomposition:
- Package keypad_pkg:
  - key_code_t (logic [3:0]).
  - keypad_state_t enum {IDLE, DEBOUNCE_PRESS, PRESSED, DEBOUNCE_RELEASE}.
  - Constants KEYPAD_ROWS=4, KEYPAD_COLS=4.
  - Classification enum {SCAN_NONE, SCAN_SINGLE, SCAN_MULTI}.
- Sub-module keypad_debounce:
  - Holds the FSM and the count.
  - Inputs: scan_done, classification, key index.
  - Outputs: key_valid, key_code, key_held.
- The top level keeps the slot/row counters, the synchronizer and the snapshot.

Test Plan:
- Idle scan: no keys, defaults → row_out cycles 1110, 1101, 1011, 0111, 8 cycles each, period 32. key_valid never asserts; key_held=0.
- Clean press of row2/col1: model pulls col_in[1] low whenever row_out[2]==0.
  - Exactly one key_valid pulse 4 scans (~128 cycles) after first sample, with key_code=9, key_held=1.
  - Holding for 20 more scans gives no further pulse.
- Bounce: key 9 present 2 scans, absent 1, present 4 → exactly one key_valid, at the end of the 4th present scan.
- Ghosting: keys 0 and 5 pressed together from IDLE → no key_valid.
  - Separately, with key 3 confirmed, adding key 12 → key_held stays 1, key_code stays 3, no strobe.
- Release bounce: after key 9 confirmed, release 3 scans then press 1 scan → no new key_valid, key_held=1. Then release 4 scans → key_held falls to 0 and key_code stays 9.
- Reset mid-operation: reset low during DEBOUNCE_PRESS, count=3, row 2 driving.
  - Outputs go to reset values immediately, without waiting for a clock edge (row_out=1110).
  - After release of reset with the key still held, key_valid occurs after 4 fresh scans.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types for the 4x4 matrix keypad scanner: key codes, debounce states
// and the per-scan classification helper.
package keypad_pkg;

  localparam int KEYPAD_ROWS = 4;
  localparam int KEYPAD_COLS = 4;
  localparam int KEYPAD_KEYS = KEYPAD_ROWS * KEYPAD_COLS;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE_PRESS,
    PRESSED,
    DEBOUNCE_RELEASE
  } keypad_state_t;

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_SINGLE,
    SCAN_MULTI
  } scan_class_t;

  typedef struct packed {
    scan_class_t cls;
    key_code_t   key;
  } scan_result_t;

  // Two or more closed switches are treated as ghosting, never as a key.
  function automatic scan_result_t classify_scan(input logic [KEYPAD_KEYS-1:0] snap);
    scan_result_t res;
    int unsigned  hits;
    res.cls = SCAN_NONE;
    res.key = '0;
    hits    = 0;
    for (int i = KEYPAD_KEYS - 1; i >= 0; i--) begin
      if (snap[i]) begin
        hits    = hits + 1;
        res.key = key_code_t'(i);
      end
    end
    if (hits == 1) begin
      res.cls = SCAN_SINGLE;
    end else if (hits > 1) begin
      res.cls = SCAN_MULTI;
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and time-set-side signals of the scanner, grouped in one bundle.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [KEYPAD_COLS-1:0] col_in;
  logic [KEYPAD_ROWS-1:0] row_out;
  logic                   key_valid;
  key_code_t              key_code;
  logic                   key_held;

  modport master (
    input  col_in,
    output row_out,
    output key_valid,
    output key_code,
    output key_held
  );

  modport slave (
    output col_in,
    input  row_out,
    input  key_valid,
    input  key_code,
    input  key_held
  );

endinterface

// File: rtl/keypad_debounce.sv
// Whole-scan debounce FSM: confirms a single key after DEBOUNCE_SCANS identical
// scans, strobes key_valid once, and holds the code until release is confirmed.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        scan_done,
  input  scan_class_t scan_class,
  input  key_code_t   scan_key,
  output logic        key_valid,
  output key_code_t   key_code,
  output logic        key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  keypad_state_t    state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  key_code_t        cand_q, cand_d;
  key_code_t        code_q, code_d;
  logic             valid_q, valid_d;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign count_inc = (count_q == CNT_MAX) ? count_q : CNT_W'(count_q + 1'b1);

  // Only scan_done moves the FSM, so key_valid can never repeat on back-to-back cycles.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    cand_d  = cand_q;
    code_d  = code_q;
    valid_d = 1'b0;
    if (scan_done) begin
      unique case (state_q)
        IDLE: begin
          if (scan_class == SCAN_SINGLE) begin
            cand_d = scan_key;
            if (CNT_MAX == CNT_ONE) begin
              state_d = PRESSED;
              code_d  = scan_key;
              valid_d = 1'b1;
              count_d = '0;
            end else begin
              state_d = DEBOUNCE_PRESS;
              count_d = CNT_ONE;
            end
          end
        end
        DEBOUNCE_PRESS: begin
          if (scan_class == SCAN_SINGLE && scan_key == cand_q) begin
            if (count_inc == CNT_MAX) begin
              state_d = PRESSED;
              code_d  = cand_q;
              valid_d = 1'b1;
              count_d = '0;
            end else begin
              count_d = count_inc;
            end
          end else begin
            state_d = IDLE;
            count_d = '0;
          end
        end
        PRESSED: begin
          if (scan_class == SCAN_NONE) begin
            if (CNT_MAX == CNT_ONE) begin
              state_d = IDLE;
              count_d = '0;
            end else begin
              state_d = DEBOUNCE_RELEASE;
              count_d = CNT_ONE;
            end
          end
        end
        DEBOUNCE_RELEASE: begin
          if (scan_class == SCAN_NONE) begin
            if (count_inc == CNT_MAX) begin
              state_d = IDLE;
              count_d = '0;
            end else begin
              count_d = count_inc;
            end
          end else begin
            state_d = PRESSED;
            count_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign key_valid = valid_q;
  assign key_code  = code_q;
  assign key_held  = (state_q == PRESSED) || (state_q == DEBOUNCE_RELEASE);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes rows low one at a time, samples the
// synchronized active-low columns and hands each full scan to the debouncer.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIVIDER   = 8,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk_in,
  input  logic             reset,
  keypad_scanner_if.master bus
);

  if (SCAN_DIVIDER < 3) begin : g_bad_divider
    $error("keypad_scanner: SCAN_DIVIDER must be >= 3");
  end
  if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
    $error("keypad_scanner: DEBOUNCE_SCANS must be >= 1");
  end

  localparam int SLOT_W = $clog2(SCAN_DIVIDER);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIVIDER - 1);

  logic [KEYPAD_COLS-1:0] col_meta, col_sync;
  logic [SLOT_W-1:0]      slot_cnt;
  logic [1:0]             row_idx;
  logic [KEYPAD_KEYS-1:0] snapshot;
  logic                   scan_done;
  logic                   slot_end;
  scan_result_t           scan_res;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      col_meta <= '1;
      col_sync <= '1;
    end else begin
      col_meta <= bus.col_in;
      col_sync <= col_meta;
    end
  end

  assign slot_end = (slot_cnt == SLOT_LAST);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      slot_cnt <= '0;
      row_idx  <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      row_idx  <= row_idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Sampling on the last cycle of each slot gives the column lines the whole slot
  // (minus the synchronizer delay) to settle after the row changes.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      snapshot  <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= slot_end && (row_idx == 2'd3);
      if (slot_end) begin
        snapshot[row_idx*KEYPAD_COLS +: KEYPAD_COLS] <= ~col_sync;
      end
    end
  end

  assign bus.row_out = ~(4'b0001 << row_idx);
  assign scan_res    = classify_scan(snapshot);

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk_in    (clk_in),
    .reset     (reset),
    .scan_done (scan_done),
    .scan_class(scan_res.cls),
    .scan_key  (scan_res.key),
    .key_valid (bus.key_valid),
    .key_code  (bus.key_code),
    .key_held  (bus.key_held)
  );

endmodule
